// File: rtl/pio_edge_irq.sv
// -----------------------------------------------------------------------------
// pio_edge_irq
//
// Multi-channel interrupt-capable input port on an Avalon-MM slave. Each of the
// WIDTH asynchronous inputs passes through a synchroniser chain, a programmable
// debounce filter and an event detector (rising / falling / any edge /
// level-high). Detected events latch into a write-1-to-clear capture register,
// which is masked and OR-reduced into a single interrupt line.
//
// Ports:
//   clk         system clock (single domain)
//   reset_n     asynchronous active-low reset
//   address     register word address
//   chipselect  slave select; write = chipselect & ~write_n
//   write_n     active-low write strobe
//   writedata   write data
//   readdata    registered read data (address sampled one cycle earlier)
//   in_port     asynchronous channel inputs
//   irq         active-high interrupt = |(capture & mask)
//
// Register map (unused bits read 0):
//   0 DATA      RO   filtered channel values
//   1 MODE      RW   2 bits per channel: 00 rise, 01 fall, 10 any, 11 level
//   2 MASK      RW   interrupt mask
//   3 CAPTURE   W1C  latched events
//   4 DEBOUNCE  RW   threshold T; a write also zeroes all channel counters
//   5 PENDING   RO   capture & mask
//   6..7        read 0, writes ignored
// -----------------------------------------------------------------------------
module pio_edge_irq #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_W  = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    typedef enum logic [2:0] {
        ADDR_DATA     = 3'd0,
        ADDR_MODE     = 3'd1,
        ADDR_MASK     = 3'd2,
        ADDR_CAPTURE  = 3'd3,
        ADDR_DEBOUNCE = 3'd4,
        ADDR_PENDING  = 3'd5
    } reg_addr_e;

    typedef enum logic [1:0] {
        MODE_RISE  = 2'b00,
        MODE_FALL  = 2'b01,
        MODE_ANY   = 2'b10,
        MODE_LEVEL = 2'b11
    } edge_mode_e;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0]                  w_sync;
    logic [WIDTH-1:0]                  r_filt;
    logic [WIDTH-1:0]                  r_filt_d;
    logic [WIDTH-1:0][DEBOUNCE_W-1:0]  r_cnt;
    logic [2*WIDTH-1:0]                r_mode;
    logic [WIDTH-1:0]                  r_mask;
    logic [WIDTH-1:0]                  r_cap;
    logic [DEBOUNCE_W-1:0]             r_thresh;
    logic [31:0]                       r_readdata;

    logic                              w_wr;
    logic                              w_wr_mode;
    logic                              w_wr_mask;
    logic                              w_wr_cap;
    logic                              w_wr_deb;
    logic [WIDTH-1:0]                  w_rise;
    logic [WIDTH-1:0]                  w_fall;
    logic [WIDTH-1:0]                  w_set;
    logic [WIDTH-1:0]                  w_clr;
    logic [31:0]                       w_rdata;
    logic                              w_unused_wdata;

    // Only the low bits of writedata reach any register.
    assign w_unused_wdata = ^writedata;

    assign w_wr      = chipselect & ~write_n;
    assign w_wr_mode = w_wr && (address == ADDR_MODE);
    assign w_wr_mask = w_wr && (address == ADDR_MASK);
    assign w_wr_cap  = w_wr && (address == ADDR_CAPTURE);
    assign w_wr_deb  = w_wr && (address == ADDR_DEBOUNCE);

    // ------------------------------------------------------------------ sync
    // Stage 0 samples in_port; the last stage is the synchronised value.
    // NOTE: sequential state uses non-blocking assignments so every flop in the
    // chain samples its predecessor's pre-edge value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], in_port};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    // -------------------------------------------------------------- debounce
    // A channel must disagree with its filtered value for T+1 consecutive
    // cycles before filt follows. The counter is cleared whenever it reaches T,
    // so it never exceeds T and cannot wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_filt   <= '0;
            r_filt_d <= '0;
            r_cnt    <= '0;
        end else begin
            r_filt_d <= r_filt;
            for (int i = 0; i < WIDTH; i++) begin
                if (w_sync[i] == r_filt[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == r_thresh) begin
                    r_filt[i] <= w_sync[i];
                    r_cnt[i]  <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + DEBOUNCE_W'(1);
                end
            end
            // A new threshold restarts every in-flight debounce window.
            if (w_wr_deb) begin
                r_cnt <= '0;
            end
        end
    end

    // ---------------------------------------------------------------- events
    assign w_rise = r_filt & ~r_filt_d;
    assign w_fall = ~r_filt & r_filt_d;

    // NOTE: every always_comb output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_set = '0;
        for (int i = 0; i < WIDTH; i++) begin
            case (edge_mode_e'(r_mode[2*i +: 2]))
                MODE_RISE:  w_set[i] = w_rise[i];
                MODE_FALL:  w_set[i] = w_fall[i];
                MODE_ANY:   w_set[i] = w_rise[i] | w_fall[i];
                MODE_LEVEL: w_set[i] = r_filt[i];
                default:    w_set[i] = 1'b0;
            endcase
        end
    end

    assign w_clr = w_wr_cap ? writedata[WIDTH-1:0] : '0;

    // ------------------------------------------------------- control registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mode   <= '0;
            r_mask   <= '0;
            r_cap    <= '0;
            r_thresh <= '0;
        end else begin
            if (w_wr_mode) r_mode   <= writedata[2*WIDTH-1:0];
            if (w_wr_mask) r_mask   <= writedata[WIDTH-1:0];
            if (w_wr_deb)  r_thresh <= writedata[DEBOUNCE_W-1:0];
            // Set is OR-ed in after the clear, so a simultaneous event wins.
            r_cap <= (r_cap & ~w_clr) | w_set;
        end
    end

    assign irq = |(r_cap & r_mask);

    // ------------------------------------------------------------- read path
    always_comb begin
        w_rdata = '0;
        case (reg_addr_e'(address))
            ADDR_DATA:     w_rdata[WIDTH-1:0]      = r_filt;
            ADDR_MODE:     w_rdata[2*WIDTH-1:0]    = r_mode;
            ADDR_MASK:     w_rdata[WIDTH-1:0]      = r_mask;
            ADDR_CAPTURE:  w_rdata[WIDTH-1:0]      = r_cap;
            ADDR_DEBOUNCE: w_rdata[DEBOUNCE_W-1:0] = r_thresh;
            ADDR_PENDING:  w_rdata[WIDTH-1:0]      = r_cap & r_mask;
            default:       w_rdata                 = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rdata;
        end
    end

    assign readdata = r_readdata;

endmodule

// File: doc/pio_edge_irq.md
# pio_edge_irq

Parametrised, multi-channel interrupt-capable input port on the Avalon-MM control bus. It synchronises WIDTH asynchronous status inputs (HDMI receiver interrupt, hot-plug, lock, etc.) and filters them with a programmable debounce counter. Each channel captures a rising, falling, any-edge or level event and drives a single masked interrupt line to the CPU.

## Interface
Parameters:
- WIDTH, 4, number of input channels (1..16).
- SYNC_STAGES, 2, synchroniser flops per channel (2..4).
- DEBOUNCE_W, 8, width of the debounce threshold register and of each per-channel counter.

Ports:
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  3  register word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- in_port  in  WIDTH  asynchronous channel inputs.
- irq  out  1  interrupt request, active high.

## Operation
- A write occurs when chipselect=1 and write_n=0. Reads are not qualified: readdata is updated every cycle from address.
- Register map; unused bits read 0; addresses 6..7 read 0 and ignore writes:
  - 0 DATA (RO): filtered channel values filt[WIDTH-1:0].
  - 1 MODE (RW): 2 bits per channel, ch i at [2i+1:2i]. 00 rising, 01 falling, 10 any edge, 11 level-high.
  - 2 MASK (RW): irq_mask[WIDTH-1:0].
  - 3 CAPTURE (R/W1C): capture[WIDTH-1:0]. Writing 1 clears a bit; writing 0 has no effect.
  - 4 DEBOUNCE (RW): threshold T[DEBOUNCE_W-1:0]. A write also zeroes all channel counters.
  - 5 PENDING (RO): capture & irq_mask.
- Per channel pipeline: in_port → SYNC_STAGES flops → sync.
- Debounce, per channel:
  - If sync==filt, cnt<=0.
  - Else if cnt==T, filt<=sync and cnt<=0.
  - Else cnt<=cnt+1.
  - cnt saturates logic-free: it never exceeds T, so there is no wrap-around.
- Event, per channel, evaluated on the cycle filt changes (the update cycle):
  - rise = filt 0→1; fall = filt 1→0.
  - Modes 00/01/10 set capture on rise / fall / either.
  - Mode 11 sets capture on every cycle filt==1.
- Capture priority: a set event beats a W1C clear in the same cycle. The bit stays 1.
- irq = |(capture & irq_mask), combinational from registers.
- A MODE change takes effect the next cycle. It never alters existing capture bits.
- A MASK change affects irq in the same cycle the register updates.

## Timing
- Reset values:
  - readdata=0, irq=0.
  - MODE=0, MASK=0, CAPTURE=0, T=0.
  - All sync flops, filt and cnt are 0.
- An input held high through reset deassertion produces a rising event once filtered. This is intended.
- Input-to-filt latency:
  - With T=0: filt follows sync 1 cycle later.
  - In general: SYNC_STAGES + T + 1 cycles after a stable change at in_port.
- A pulse shorter than T+1 cycles at sync is rejected.
- Capture bit sets 1 cycle after filt changes. irq asserts in that same cycle if masked in.
- Read latency: readdata reflects the address sampled 1 cycle earlier, i.e. the register contents as of that edge.
- Register writes take effect at the clock edge of the write cycle.
- Reset asserted mid-debounce or mid-capture immediately returns all state to reset values, with no pending event retained.

## Test plan
- Reset, then in_port=0, MASK=1, MODE=0, T=0. Drive ch0 0→1. Required: DATA bit0=1 after 3 cycles, CAPTURE=0x1 and irq=1 after 4 cycles. Write CAPTURE=0x1. Required: irq=0 next cycle.
- T=5, ch1 mode 01, ch1 preset high. Apply a 4-cycle low glitch. Required: no capture. Apply a 6-cycle low. Required: CAPTURE bit1=1, DATA bit1=0 until input returns high and 6 stable cycles elapse.
- Ch2 mode 10, MASK=0x4. Toggle ch2 twice, separated by more than T+1 cycles. Required: capture set after each edge. A W1C clear between the edges drops irq, and the second edge re-raises it.
- Ch3 mode 11, in_port[3]=1 held, MASK=0x8. Write CAPTURE=0x8. Required: bit stays 1 and irq stays 1. Release input, then clear. Required: bit 0.
- Edge event on ch0 in the same cycle as a W1C write 0x1. Required: CAPTURE bit0=1 afterwards. MASK=0 with capture set. Required: irq=0 and PENDING=0.
- Read addresses 0..7 after writes MODE=0xA5, MASK=0xF, T=0x3. Required: exact readback with 1-cycle latency, 0 at addresses 6/7. Assert reset_n mid-debounce. Required: all registers 0 and irq=0 immediately.
